// File: rtl/osc_monitor_pkg.sv
// Shared state encoding and default parameters for the oscillator monitor.
package osc_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    LOCKED  = 3'd3,
    STALLED = 3'd4
  } state_t;

  localparam int unsigned DEF_PER_W       = 8;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_STALL_LIMIT = 16;
  localparam int unsigned DEF_LOCK_COUNT  = 3;

endpackage

// File: rtl/osc_edge_det.sv
// Registers y_in once and derives rise/fall/any-edge strobes against the previous sample.
module osc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic y_in,
  output logic rise,
  output logic fall,
  output logic any_edge
);

  logic y_q;

  // Reset loads the live input so the first cycle after reset never reports an edge.
  always_ff @(posedge clk) begin
    if (!rst) y_q <= y_in;
    else      y_q <= y_in;
  end

  assign rise     = y_in & ~y_q;
  assign fall     = ~y_in & y_q;
  assign any_edge = rise | fall;

endmodule

// File: rtl/osc_monitor.sv
// Measures the rising-to-rising period of y_in and reports lock/stall status.
module osc_monitor
  import osc_monitor_pkg::*;
#(
  parameter int unsigned PER_W       = DEF_PER_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             y_in,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             locked,
  output logic             stalled,
  output logic [2:0]       state
);

  localparam logic [PER_W-1:0] RUN_MAX   = '1;
  localparam logic [PER_W-1:0] STALL_LIM = PER_W'(STALL_LIMIT);
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_COUNT);

  state_t           st;
  logic [PER_W-1:0] run_cnt;
  logic [PER_W-1:0] stall_cnt;
  logic [3:0]       match_cnt;

  logic             rise;
  logic             fall;
  logic             any_edge;

  logic [PER_W-1:0] stall_inc;
  logic             stall_hit;
  logic [3:0]       match_nxt;

  osc_edge_det u_edge (
    .clk      (clk),
    .rst      (rst),
    .y_in     (y_in),
    .rise     (rise),
    .fall     (fall),
    .any_edge (any_edge)
  );

  always_comb begin
    stall_inc = '0;
    stall_hit = 1'b0;
    match_nxt = '0;
    stall_inc = (stall_cnt == STALL_LIM) ? stall_cnt : stall_cnt + PER_W'(1);
    // An edge in the threshold cycle clears the counter, so it always beats the stall.
    stall_hit = !any_edge && (stall_inc == STALL_LIM);
    if (run_cnt == period)
      match_nxt = (match_cnt == LOCK_N) ? match_cnt : match_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st           <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      edge_cnt     <= '0;
      locked       <= 1'b0;
      stalled      <= 1'b0;
      run_cnt      <= '0;
      stall_cnt    <= '0;
      match_cnt    <= '0;
    end else begin
      period_valid <= 1'b0;
      if (!en) begin
        st        <= IDLE;
        run_cnt   <= '0;
        stall_cnt <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
        stalled   <= 1'b0;
      end else begin
        if (rise)                 run_cnt <= PER_W'(1);
        else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + PER_W'(1);

        if (any_edge) begin
          stall_cnt <= '0;
          if (st != IDLE) edge_cnt <= edge_cnt + CNT_W'(1);
        end else if (st == ARM || st == MEASURE || st == LOCKED) begin
          stall_cnt <= stall_inc;
        end

        unique case (st)
          IDLE: st <= ARM;
          ARM: begin
            if (rise) begin
              st <= MEASURE;
            end else if (stall_hit) begin
              st      <= STALLED;
              stalled <= 1'b1;
            end
          end
          // MEASURE and LOCKED share one path: a saturated match count means lock,
          // a cleared one (mismatch) falls back to MEASURE.
          MEASURE, LOCKED: begin
            if (rise) begin
              period       <= run_cnt;
              period_valid <= 1'b1;
              match_cnt    <= match_nxt;
              if (match_nxt == LOCK_N) begin
                st     <= LOCKED;
                locked <= 1'b1;
              end else begin
                st     <= MEASURE;
                locked <= 1'b0;
              end
            end else if (stall_hit) begin
              st      <= STALLED;
              stalled <= 1'b1;
              locked  <= 1'b0;
            end
          end
          STALLED: begin
            if (rise) begin
              st        <= MEASURE;
              stalled   <= 1'b0;
              match_cnt <= '0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_osc_monitor.sv
// Directed table, corner-case sequences and random stimulus against a timestamp-based model.
module tb_osc_monitor;

  localparam int PW    = 8;
  localparam int CW    = 16;
  localparam int STALL = 16;
  localparam int LOCK  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          y_in = 1'b0;
  logic [PW-1:0] period;
  logic          period_valid;
  logic [CW-1:0] edge_cnt;
  logic          locked;
  logic          stalled;
  logic [2:0]    state;

  int tests = 0;
  int fails = 0;

  osc_monitor #(
    .PER_W       (PW),
    .CNT_W       (CW),
    .STALL_LIMIT (STALL),
    .LOCK_COUNT  (LOCK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .y_in         (y_in),
    .period       (period),
    .period_valid (period_valid),
    .edge_cnt     (edge_cnt),
    .locked       (locked),
    .stalled      (stalled),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Model: periods and stall from cycle timestamps rather than counters.
  int            m_n = 0;
  int            m_mode = 0;
  int            m_last_rise = 0;
  int            m_stall_ref = 0;
  int            m_matches = 0;
  bit            m_yprev = 1'b0;
  logic [PW-1:0] m_period = '0;
  bit            m_pv = 1'b0;
  logic [CW-1:0] m_ec = '0;
  bit            m_locked = 1'b0;
  bit            m_stalled = 1'b0;

  task automatic model_step(input bit r, input bit e, input bit yv);
    bit rise, fall;
    int p;
    m_n++;
    rise = yv && !m_yprev;
    fall = !yv && m_yprev;
    m_yprev = yv;
    m_pv = 1'b0;
    if (!r) begin
      m_mode = 0; m_period = '0; m_ec = '0; m_locked = 0; m_stalled = 0;
      m_matches = 0; m_stall_ref = m_n;
    end else if (!e) begin
      m_mode = 0; m_locked = 0; m_stalled = 0; m_matches = 0;
    end else begin
      if (m_mode != 0 && (rise || fall)) m_ec++;
      if (rise || fall) m_stall_ref = m_n;
      case (m_mode)
        0: begin m_mode = 1; m_stall_ref = m_n; end
        1: begin
          if (rise) begin m_mode = 2; m_last_rise = m_n; end
          else if (m_n - m_stall_ref >= STALL) begin m_mode = 4; m_stalled = 1; end
        end
        2, 3: begin
          if (rise) begin
            p = m_n - m_last_rise;
            if (p > (1 << PW) - 1) p = (1 << PW) - 1;
            if (p == int'(m_period)) m_matches = (m_matches + 1 > LOCK) ? LOCK : m_matches + 1;
            else m_matches = 0;
            m_period = p[PW-1:0];
            m_pv = 1'b1;
            m_last_rise = m_n;
            m_mode = (m_matches == LOCK) ? 3 : 2;
            m_locked = (m_matches == LOCK);
          end else if (m_n - m_stall_ref >= STALL) begin
            m_mode = 4; m_stalled = 1; m_locked = 0;
          end
        end
        default: begin
          if (rise) begin
            m_mode = 2; m_stalled = 0; m_matches = 0; m_last_rise = m_n;
          end
        end
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    tests++;
    if (state !== 3'(m_mode) || period !== m_period || period_valid !== m_pv ||
        edge_cnt !== m_ec || locked !== m_locked || stalled !== m_stalled) begin
      fails++;
      $display("FAIL %s cyc=%0d got st=%0d per=%0d pv=%0b ec=%0d lk=%0b sl=%0b exp st=%0d per=%0d pv=%0b ec=%0d lk=%0b sl=%0b",
               tag, m_n, state, period, period_valid, edge_cnt, locked, stalled,
               m_mode, m_period, m_pv, m_ec, m_locked, m_stalled);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit yv, input string tag);
    rst = r; en = e; y_in = yv;
    @(posedge clk);
    model_step(r, e, yv);
    #1;
    check_model(tag);
  endtask

  // n periods of lo clocks low followed by hi clocks high; each rise opens a hi phase.
  task automatic wave(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < lo; i++) tick(1, 1, 0, "wave");
      for (int i = 0; i < hi; i++) tick(1, 1, 1, "wave");
    end
  endtask

  typedef struct {
    bit         r, e, y;
    logic [2:0] st;
    int         ec, per;
    bit         pv, lk, sl;
  } vec_t;

  vec_t tbl[28];

  initial begin
    int period_hold, ec_hold, len;
    bit yv, ev, rv;

    tbl[0]  = '{0,0,1, 3'd0, 0,0,0,0,0};
    tbl[1]  = '{1,1,1, 3'd1, 0,0,0,0,0};
    tbl[2]  = '{1,1,1, 3'd1, 0,0,0,0,0};
    tbl[3]  = '{1,1,0, 3'd1, 1,0,0,0,0};
    tbl[4]  = '{1,1,0, 3'd1, 1,0,0,0,0};
    tbl[5]  = '{1,1,1, 3'd2, 2,0,0,0,0};
    tbl[6]  = '{1,1,1, 3'd2, 2,0,0,0,0};
    tbl[7]  = '{1,1,0, 3'd2, 3,0,0,0,0};
    tbl[8]  = '{1,1,0, 3'd2, 3,0,0,0,0};
    tbl[9]  = '{1,1,1, 3'd2, 4,4,1,0,0};
    tbl[10] = '{1,1,1, 3'd2, 4,4,0,0,0};
    tbl[11] = '{1,1,0, 3'd2, 5,4,0,0,0};
    tbl[12] = '{1,1,0, 3'd2, 5,4,0,0,0};
    tbl[13] = '{1,1,1, 3'd2, 6,4,1,0,0};
    tbl[14] = '{1,1,1, 3'd2, 6,4,0,0,0};
    tbl[15] = '{1,1,0, 3'd2, 7,4,0,0,0};
    tbl[16] = '{1,1,0, 3'd2, 7,4,0,0,0};
    tbl[17] = '{1,1,1, 3'd2, 8,4,1,0,0};
    tbl[18] = '{1,1,1, 3'd2, 8,4,0,0,0};
    tbl[19] = '{1,1,0, 3'd2, 9,4,0,0,0};
    tbl[20] = '{1,1,0, 3'd2, 9,4,0,0,0};
    tbl[21] = '{1,1,1, 3'd3,10,4,1,1,0};
    tbl[22] = '{1,1,1, 3'd3,10,4,0,1,0};
    tbl[23] = '{1,1,1, 3'd3,10,4,0,1,0};
    tbl[24] = '{1,1,1, 3'd3,10,4,0,1,0};
    tbl[25] = '{1,1,0, 3'd3,11,4,0,1,0};
    tbl[26] = '{1,1,0, 3'd3,11,4,0,1,0};
    tbl[27] = '{1,1,1, 3'd2,12,6,1,0,0};

    for (int i = 0; i < 28; i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].y, "table_model");
      tests++;
      if (state !== tbl[i].st || int'(edge_cnt) != tbl[i].ec || int'(period) != tbl[i].per ||
          period_valid !== tbl[i].pv || locked !== tbl[i].lk || stalled !== tbl[i].sl) begin
        fails++;
        $display("FAIL table[%0d] got st=%0d ec=%0d per=%0d pv=%0b lk=%0b sl=%0b exp st=%0d ec=%0d per=%0d pv=%0b lk=%0b sl=%0b",
                 i, state, edge_cnt, period, period_valid, locked, stalled,
                 tbl[i].st, tbl[i].ec, tbl[i].per, tbl[i].pv, tbl[i].lk, tbl[i].sl);
      end
    end

    // Re-lock after the stretched period: one mismatch then three matches.
    tick(1, 1, 1, "relock");
    wave(3, 2, 2);
    chk("relock_not_yet", int'(locked), 0);
    wave(1, 2, 2);
    chk("relock_locked", int'(locked), 1);
    chk("relock_state", int'(state), 3);

    // Stall: exactly STALL clocks after the last edge.
    tick(1, 1, 0, "stall_fall");
    for (int i = 0; i < STALL - 1; i++) tick(1, 1, 0, "stall_wait");
    chk("stall_early", int'(stalled), 0);
    tick(1, 1, 0, "stall_hit");
    chk("stall_flag", int'(stalled), 1);
    chk("stall_state", int'(state), 4);
    chk("stall_unlock", int'(locked), 0);
    tick(1, 1, 1, "stall_exit");
    chk("stall_exit_state", int'(state), 2);
    chk("stall_exit_nopv", int'(period_valid), 0);
    chk("stall_exit_flag", int'(stalled), 0);

    // Edge exactly on the threshold cycle beats the stall.
    for (int i = 0; i < STALL - 1; i++) tick(1, 1, 1, "edge_vs_stall");
    tick(1, 1, 0, "edge_vs_stall_edge");
    chk("edge_beats_stall", int'(stalled), 0);

    // Enable drop mid-measurement holds period and edge count.
    wave(2, 2, 2);
    period_hold = int'(period);
    ec_hold = int'(edge_cnt);
    tick(1, 0, 0, "en_drop");
    chk("en_drop_state", int'(state), 0);
    chk("en_drop_period", int'(period), period_hold);
    chk("en_drop_ec", int'(edge_cnt), ec_hold + 1 - 1);
    tick(1, 0, 1, "en_low_toggle");
    tick(1, 0, 0, "en_low_toggle");
    chk("en_low_ec_hold", int'(edge_cnt), ec_hold);
    tick(1, 1, 0, "reenable");
    chk("reenable_arm", int'(state), 1);
    tick(1, 1, 1, "reenable_rise");
    chk("reenable_nopv", int'(period_valid), 0);
    chk("reenable_measure", int'(state), 2);

    // Reset while locked.
    wave(5, 2, 2);
    chk("pre_reset_locked", int'(locked), 1);
    tick(0, 1, 0, "reset_mid");
    chk("reset_state", int'(state), 0);
    chk("reset_ec", int'(edge_cnt), 0);
    chk("reset_period", int'(period), 0);
    tick(1, 1, 0, "post_reset");
    chk("post_reset_arm", int'(state), 1);
    chk("post_reset_noedge", int'(edge_cnt), 0);

    // Random phases, occasional enable drops and resets.
    yv = 1'b0;
    len = 0;
    for (int c = 0; c < 4000; c++) begin
      if (len == 0) begin
        yv = ~yv;
        len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 24) : $urandom_range(1, 5);
      end
      len--;
      ev = ($urandom_range(0, 99) != 0);
      rv = ($urandom_range(0, 299) != 0);
      tick(rv, ev, yv, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
